genome_xfer_sequencer: RTL and testbench



---
 rtl/genome_pkg.sv | 27 ++
 rtl/start_edge_det.sv | 21 ++
 rtl/genome_xfer_sequencer.sv | 167 ++++++++++++++++
 tb/tb_genome_xfer_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genome_pkg.sv
// Shared types and constants for the genomics kernel transfer sequencer.
// The body-size helper sits here so that the kernel top can reuse it.
package genome_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrStart,
    StHdrWait,
    StBodyStart,
    StBodyWait,
    StDone
  } seq_state_e;

  localparam int unsigned HDR_BYTES      = 4;
  localparam int unsigned BODY_OFFSET    = 256;
  localparam int unsigned BEAT_BYTES     = 64;
  localparam int unsigned MAX_BODY_BYTES = 16384;

  // Clamp to MAX_BODY_BYTES, then round up to whole beats.
  // The 33-bit width absorbs the carry out of the round-up.
  function automatic logic [32:0] body_size(input logic [31:0] len);
    logic [32:0] clamped;
    clamped = (len > MAX_BODY_BYTES) ? 33'(MAX_BODY_BYTES) : {1'b0, len};
    return (clamped + 33'(BEAT_BYTES - 1)) & ~33'(BEAT_BYTES - 1);
  endfunction

endpackage

// File: rtl/start_edge_det.sv
// Registers a level input and produces a one-cycle pulse on its rising edge.
module start_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/genome_xfer_sequencer.sv
// Two-phase transfer controller: reads a header to learn the body length, then runs the
// read and write engines together over the body. Drives the ap_idle/ap_done handshake.
module genome_xfer_sequencer
  import genome_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned SIZE_W = 32
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic [ADDR_W-1:0] ctrl_src_addr,
  input  logic [ADDR_W-1:0] ctrl_dst_addr,
  output logic              rd_start,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [SIZE_W-1:0] rd_size,
  input  logic              rd_done,
  input  logic              hdr_tvalid,
  input  logic [31:0]       hdr_tdata,
  output logic              wr_start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SIZE_W-1:0] wr_size,
  input  logic              wr_done,
  output logic              err_clamped
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [31:0]       body_len_q, body_len_d;
  logic              hdr_seen_q, hdr_seen_d;
  logic              rd_seen_q, rd_seen_d;
  logic              wr_seen_q, wr_seen_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [SIZE_W-1:0] rd_size_q, rd_size_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [SIZE_W-1:0] wr_size_q, wr_size_d;
  logic              err_q, err_d;

  logic              start_pulse;
  logic [31:0]       eff_len;
  logic [SIZE_W-1:0] body_sz;

  start_edge_det u_start_edge (
    .clk  (ap_clk),
    .rst  (areset),
    .sig  (ap_start),
    .rise (start_pulse)
  );

  // A header beat arriving in the same cycle as rd_done still counts.
  assign eff_len = hdr_seen_q ? body_len_q : (hdr_tvalid ? hdr_tdata : 32'd0);
  assign body_sz = SIZE_W'(body_size(eff_len));

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      body_len_q <= '0;
      hdr_seen_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      wr_addr_q  <= '0;
      wr_size_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      body_len_q <= body_len_d;
      hdr_seen_q <= hdr_seen_d;
      rd_seen_q  <= rd_seen_d;
      wr_seen_q  <= wr_seen_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      wr_addr_q  <= wr_addr_d;
      wr_size_q  <= wr_size_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    body_len_d = body_len_q;
    hdr_seen_d = hdr_seen_q;
    rd_seen_d  = rd_seen_q;
    wr_seen_d  = wr_seen_q;
    rd_addr_d  = rd_addr_q;
    rd_size_d  = rd_size_q;
    wr_addr_d  = wr_addr_q;
    wr_size_d  = wr_size_q;
    err_d      = err_q;
    ap_idle    = 1'b0;
    ap_done    = 1'b0;
    rd_start   = 1'b0;
    wr_start   = 1'b0;

    case (state_q)
      StIdle: begin
        ap_idle = 1'b1;
        if (start_pulse) begin
          src_d      = ctrl_src_addr;
          dst_d      = ctrl_dst_addr;
          body_len_d = '0;
          hdr_seen_d = 1'b0;
          rd_seen_d  = 1'b0;
          wr_seen_d  = 1'b0;
          err_d      = 1'b0;
          rd_addr_d  = ctrl_src_addr;
          rd_size_d  = SIZE_W'(HDR_BYTES);
          state_d    = StHdrStart;
        end
      end
      StHdrStart: begin
        rd_start = 1'b1;
        state_d  = StHdrWait;
      end
      StHdrWait: begin
        if (hdr_tvalid && !hdr_seen_q) begin
          body_len_d = hdr_tdata;
          hdr_seen_d = 1'b1;
        end
        if (rd_done) begin
          if (eff_len == 32'd0) begin
            state_d = StDone;
          end else begin
            err_d     = (eff_len > MAX_BODY_BYTES);
            rd_addr_d = src_q + ADDR_W'(BODY_OFFSET);
            rd_size_d = body_sz;
            wr_addr_d = dst_q;
            wr_size_d = body_sz;
            state_d   = StBodyStart;
          end
        end
      end
      StBodyStart: begin
        rd_start = 1'b1;
        wr_start = 1'b1;
        state_d  = StBodyWait;
      end
      StBodyWait: begin
        if (rd_done) rd_seen_d = 1'b1;
        if (wr_done) wr_seen_d = 1'b1;
        if ((rd_seen_q | rd_done) & (wr_seen_q | wr_done)) state_d = StDone;
      end
      StDone: begin
        ap_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr     = rd_addr_q;
  assign rd_size     = rd_size_q;
  assign wr_addr     = wr_addr_q;
  assign wr_size     = wr_size_q;
  assign err_clamped = err_q;

endmodule

// File: tb/tb_genome_xfer_sequencer.sv
// Directed bench for genome_xfer_sequencer: header/body phases, sizing, done ordering
// and start/reset handling, with hand-computed expectations.
module tb_genome_xfer_sequencer;

  logic        clk = 1'b0;
  logic        areset;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic [63:0] ctrl_src_addr;
  logic [63:0] ctrl_dst_addr;
  logic        rd_start;
  logic [63:0] rd_addr;
  logic [31:0] rd_size;
  logic        rd_done;
  logic        hdr_tvalid;
  logic [31:0] hdr_tdata;
  logic        wr_start;
  logic [63:0] wr_addr;
  logic [31:0] wr_size;
  logic        wr_done;
  logic        err_clamped;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  genome_xfer_sequencer #(
    .ADDR_W (64),
    .SIZE_W (32)
  ) dut (
    .ap_clk        (clk),
    .areset        (areset),
    .ap_start      (ap_start),
    .ap_idle       (ap_idle),
    .ap_done       (ap_done),
    .ctrl_src_addr (ctrl_src_addr),
    .ctrl_dst_addr (ctrl_dst_addr),
    .rd_start      (rd_start),
    .rd_addr       (rd_addr),
    .rd_size       (rd_size),
    .rd_done       (rd_done),
    .hdr_tvalid    (hdr_tvalid),
    .hdr_tdata     (hdr_tdata),
    .wr_start      (wr_start),
    .wr_addr       (wr_addr),
    .wr_size       (wr_size),
    .wr_done       (wr_done),
    .err_clamped   (err_clamped)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (ap_done) done_cnt++;
    if (rd_start) rd_cnt++;
    if (wr_start) wr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in HDR_START, observed 1 time unit after the edge
  task automatic start_run(input logic [63:0] s, input logic [63:0] d);
    ctrl_src_addr = s;
    ctrl_dst_addr = d;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  // mode 0: no beat, 1: early beat plus an ignored junk beat, 2: beat with rd_done
  task automatic hdr_phase(input logic [31:0] data, input int mode);
    tick();
    if (mode == 1) begin
      hdr_tvalid = 1'b1;
      hdr_tdata  = data;
      tick();
      hdr_tdata  = 32'h00ff_0000;
      tick();
      hdr_tvalid = 1'b0;
      tick();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
    end else begin
      tick();
      tick();
      if (mode == 2) begin
        hdr_tvalid = 1'b1;
        hdr_tdata  = data;
      end
      rd_done = 1'b1;
      tick();
      rd_done    = 1'b0;
      hdr_tvalid = 1'b0;
    end
  endtask

  // From BODY_START; leaves the DUT in DONE. mode 0: wr then rd, 1: both, 2: rd then wr
  task automatic body_done(input int mode);
    tick();
    if (mode == 1) begin
      rd_done = 1'b1;
      wr_done = 1'b1;
      tick();
      rd_done = 1'b0;
      wr_done = 1'b0;
    end else begin
      if (mode == 0) wr_done = 1'b1; else rd_done = 1'b1;
      tick();
      wr_done = 1'b0;
      rd_done = 1'b0;
      tick();
      if (mode == 0) rd_done = 1'b1; else wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      rd_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick();
    tick();
    checks++;
    if ({ap_idle, ap_done, rd_start, wr_start, err_clamped} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got idle/done/rs/ws/err=%b want 10000",
               {ap_idle, ap_done, rd_start, wr_start, err_clamped});
    end
    checks++;
    if ({rd_addr, rd_size, wr_addr, wr_size} !== '0) begin
      errors++;
      $display("FAIL reset_addr_size: got rd %h/%0d wr %h/%0d want all 0",
               rd_addr, rd_size, wr_addr, wr_size);
    end
    areset = 1'b0;
    tick();
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 1", ap_idle);
    end
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    start_run(64'h1000, 64'h8000);
    checks++;
    if ({rd_start, wr_start, ap_idle} !== 3'b100 || rd_addr !== 64'h1000 || rd_size !== 32'd4)
    begin
      errors++;
      $display("FAIL hdr_start: got rs/ws/idle=%b addr=%h size=%0d want 100 1000 4",
               {rd_start, wr_start, ap_idle}, rd_addr, rd_size);
    end
    hdr_phase(32'h100, 1);
    checks++;
    if ({rd_start, wr_start} !== 2'b11 || rd_addr !== 64'h1100 || wr_addr !== 64'h8000) begin
      errors++;
      $display("FAIL body_start: got rs/ws=%b rd=%h wr=%h want 11 1100 8000",
               {rd_start, wr_start}, rd_addr, wr_addr);
    end
    checks++;
    if (rd_size !== 32'd256 || wr_size !== 32'd256 || err_clamped !== 1'b0) begin
      errors++;
      $display("FAIL body_size: got rd=%0d wr=%0d err=%b want 256 256 0",
               rd_size, wr_size, err_clamped);
    end
    body_done(0);
    checks++;
    if (ap_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: got %b want 1", ap_done);
    end
    tick();
    checks++;
    if ({ap_done, ap_idle} !== 2'b01 || rd_addr !== 64'h1100 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL basic_after: got done/idle=%b rd=%h pulses=%0d want 01 1100 %0d",
               {ap_done, ap_idle}, rd_addr, done_cnt - d0, 1);
    end
  endtask

  task automatic test_zero_body();
    int r0;
    int w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    start_run(64'h2000, 64'h9000);
    hdr_phase(32'd0, 1);
    checks++;
    if (ap_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_done: got %b want 1", ap_done);
    end
    tick();
    checks++;
    if (rd_cnt !== r0 + 1 || wr_cnt !== w0) begin
      errors++;
      $display("FAIL zero_len_starts: got rd=%0d wr=%0d want 1 0", rd_cnt - r0, wr_cnt - w0);
    end
    start_run(64'h2000, 64'h9000);
    hdr_phase(32'd0, 0);
    checks++;
    if (ap_done !== 1'b1) begin
      errors++;
      $display("FAIL no_beat_done: got %b want 1", ap_done);
    end
    tick();
  endtask

  task automatic test_round_clamp();
    start_run(64'h3000, 64'hA000);
    hdr_phase(32'd100, 2);
    checks++;
    if (rd_size !== 32'd128 || wr_size !== 32'd128 || err_clamped !== 1'b0) begin
      errors++;
      $display("FAIL round_100: got rd=%0d wr=%0d err=%b want 128 128 0",
               rd_size, wr_size, err_clamped);
    end
    body_done(1);
    tick();
    start_run(64'h3000, 64'hA000);
    hdr_phase(32'd20000, 1);
    checks++;
    if (rd_size !== 32'd16384 || wr_size !== 32'd16384 || err_clamped !== 1'b1) begin
      errors++;
      $display("FAIL clamp_20000: got rd=%0d wr=%0d err=%b want 16384 16384 1",
               rd_size, wr_size, err_clamped);
    end
    body_done(1);
    tick();
    checks++;
    if (err_clamped !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err_clamped);
    end
    start_run(64'h3000, 64'hA000);
    checks++;
    if (err_clamped !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_start: got %b want 0", err_clamped);
    end
    hdr_phase(32'd64, 1);
    checks++;
    if (rd_size !== 32'd64) begin
      errors++;
      $display("FAIL exact_beat: got %0d want 64", rd_size);
    end
    body_done(1);
    tick();
  endtask

  task automatic test_done_ordering();
    int d0;
    int r0;
    for (int m = 0; m < 3; m++) begin
      d0 = done_cnt;
      start_run(64'h5000, 64'hB000);
      hdr_phase(32'd64, 1);
      body_done(m);
      checks++;
      if (ap_done !== 1'b1) begin
        errors++;
        $display("FAIL order_%0d_done: got %b want 1", m, ap_done);
      end
      tick();
      tick();
      checks++;
      if (done_cnt !== d0 + 1) begin
        errors++;
        $display("FAIL order_%0d_count: got %0d pulses want 1", m, done_cnt - d0);
      end
    end
    d0 = done_cnt;
    r0 = rd_cnt;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
    tick();
    checks++;
    if (ap_idle !== 1'b1 || done_cnt !== d0 || rd_cnt !== r0) begin
      errors++;
      $display("FAIL stray_rd_done: got idle=%b done=%0d rs=%0d want 1 0 0",
               ap_idle, done_cnt - d0, rd_cnt - r0);
    end
  endtask

  task automatic test_start_handling();
    int d0;
    int r0;
    // Held-high start runs once
    d0 = done_cnt;
    r0 = rd_cnt;
    ctrl_src_addr = 64'h6000;
    ctrl_dst_addr = 64'hC000;
    ap_start = 1'b1;
    tick();
    hdr_phase(32'd0, 0);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (ap_idle !== 1'b1 || done_cnt !== d0 + 1 || rd_cnt !== r0 + 1) begin
      errors++;
      $display("FAIL held_start: got idle=%b done=%0d rs=%0d want 1 1 1",
               ap_idle, done_cnt - d0, rd_cnt - r0);
    end
    ap_start = 1'b0;
    tick();
    // Edge while busy is dropped
    d0 = done_cnt;
    r0 = rd_cnt;
    start_run(64'h6000, 64'hC000);
    tick();
    ap_start   = 1'b1;
    hdr_tvalid = 1'b1;
    hdr_tdata  = 32'd64;
    tick();
    ap_start   = 1'b0;
    hdr_tvalid = 1'b0;
    rd_done    = 1'b1;
    tick();
    rd_done = 1'b0;
    body_done(1);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (ap_idle !== 1'b1 || done_cnt !== d0 + 1 || rd_cnt !== r0 + 2) begin
      errors++;
      $display("FAIL busy_edge: got idle=%b done=%0d rs=%0d want 1 1 2",
               ap_idle, done_cnt - d0, rd_cnt - r0);
    end
    // Reset in BODY_WAIT aborts without a done pulse
    d0 = done_cnt;
    start_run(64'h6000, 64'hC000);
    hdr_phase(32'd64, 1);
    tick();
    areset = 1'b1;
    tick();
    checks++;
    if ({ap_idle, ap_done} !== 2'b10 || rd_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_abort: got idle/done=%b rd=%h want 10 0", {ap_idle, ap_done}, rd_addr);
    end
    areset = 1'b0;
    tick();
    tick();
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    start_run(64'h4000, 64'h5000);
    checks++;
    if (rd_addr !== 64'h4000 || rd_start !== 1'b1) begin
      errors++;
      $display("FAIL fresh_hdr: got rs=%b rd=%h want 1 4000", rd_start, rd_addr);
    end
    hdr_phase(32'd128, 1);
    checks++;
    if (rd_addr !== 64'h4100 || wr_addr !== 64'h5000 || wr_size !== 32'd128) begin
      errors++;
      $display("FAIL fresh_body: got rd=%h wr=%h size=%0d want 4100 5000 128",
               rd_addr, wr_addr, wr_size);
    end
    body_done(2);
    checks++;
    if (ap_done !== 1'b1) begin
      errors++;
      $display("FAIL fresh_done: got %b want 1", ap_done);
    end
    tick();
  endtask

  initial begin
    areset        = 1'b1;
    ap_start      = 1'b0;
    ctrl_src_addr = '0;
    ctrl_dst_addr = '0;
    rd_done       = 1'b0;
    wr_done       = 1'b0;
    hdr_tvalid    = 1'b0;
    hdr_tdata     = '0;
    test_reset();
    test_basic();
    test_zero_body();
    test_round_clamp();
    test_done_ordering();
    test_start_handling();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
